branch_target_predictor: RTL and testbench

//  Parametrised direct-mapped branch target buffer with per-entry N-bit saturating counters.

---
 rtl/btp_pkg.sv | 33 +++
 rtl/btp_sat_ctr.sv | 22 ++
 rtl/branch_target_predictor.sv | 144 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btp_pkg.sv
// Shared definitions for the branch target predictor.
// Holds the default geometry, the entry/counter types at that geometry and
// the weak-state constants, plus helpers that derive the weak states for
// any counter width so parametrised instances stay consistent.
package btp_pkg;

    localparam int BTP_ENTRIES = 64;
    localparam int BTP_TAG_W   = 8;
    localparam int BTP_CTR_W   = 2;
    localparam int BTP_GHR_W   = 6;

    typedef logic [BTP_CTR_W-1:0] ctr_t;

    // One BTB line; pc[1:0] of a target is always zero, so only [31:2] is kept.
    typedef struct packed {
        logic                 valid;
        logic [BTP_TAG_W-1:0] tag;
        logic [29:0]          target;
    } btb_entry_t;

    // Weak states sit on either side of the MSB boundary (10 / 01 for 2 bits).
    function automatic logic [31:0] ctr_weak_taken(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] ctr_weak_not_taken(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    localparam ctr_t CTR_WEAK_T  = ctr_t'(ctr_weak_taken(BTP_CTR_W));
    localparam ctr_t CTR_WEAK_NT = ctr_t'(ctr_weak_not_taken(BTP_CTR_W));

endpackage

// File: rtl/btp_sat_ctr.sv
// Saturating up/down counter next-value logic for the predictor update path.
// Purely combinational: the caller owns the storage.
module btp_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    output logic [W-1:0] result
);

    // Step towards the outcome, holding at all-ones or all-zeros.
    always_comb begin
        // NOTE: result gets a default first so no path leaves it unassigned (no latch).
        result = value;
        if (inc) begin
            if (value != '1) result = value + W'(1);
        end else begin
            if (value != '0) result = value - W'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Lookup is combinational from registered state; training comes from the
// resolved branch in MEM. Define BTP_GSHARE_EN to move the counters into a
// pattern table indexed by idx ^ global history (gshare).
module branch_target_predictor
    import btp_pkg::*;
#(
    parameter int ENTRIES = BTP_ENTRIES,
    parameter int TAG_W   = BTP_TAG_W,
    parameter int CTR_W   = BTP_CTR_W,
    parameter int GHR_W   = BTP_GHR_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] lk_pc,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [31:0] lk_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_not_taken(CTR_W));
    // PC bits that take part in index or tag; the rest never influence the table.
    localparam logic [31:0] PC_USED = ((32'd1 << (IDX_W + TAG_W)) - 32'd1) << 2;

    // Geometry sanity checks at elaboration.
    generate
        if ((ENTRIES < 4) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
            $error("ENTRIES must be a power of two and at least 4");
        end
        if (CTR_W < 2) begin : g_bad_ctr
            $error("CTR_W must be at least 2");
        end
        if (IDX_W + TAG_W > 30) begin : g_bad_tag
            $error("index plus tag must fit in pc[31:2]");
        end
        if ((GHR_W < 1) || (GHR_W > IDX_W)) begin : g_bad_ghr
            $error("GHR_W must be between 1 and IDX_W");
        end
    endgenerate

    // Table storage, all flops.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] upd_cidx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_en;
    logic             line_we;
    logic [CTR_W-1:0] ctr_next;
    logic             lint_unused;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[IDX_W+2 +: TAG_W];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];

`ifdef BTP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // Counters are shared through the history hash; tag/target keep the plain index.
    assign lk_cidx  = lk_idx  ^ IDX_W'(ghr_q);
    assign upd_cidx = upd_idx ^ IDX_W'(ghr_q);

    // Global history: shift in each resolved outcome unless the update is flushed away.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ghr_q <= '0;
        end else if (upd_en) begin
            ghr_q <= GHR_W'({ghr_q, upd_taken});
        end
    end
`else
    assign lk_cidx  = lk_idx;
    assign upd_cidx = upd_idx;
`endif

    // Fetch-side lookup; a same-cycle update is not forwarded.
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_cidx][CTR_W-1];
    assign lk_target = lk_taken ? {target_q[lk_idx], 2'b00} : lk_pc + 32'd4;

    // Update-side decode; flush drops a simultaneous update entirely.
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_en  = upd_valid && !flush;
    // A taken outcome either refreshes the target on a hit or allocates on a miss;
    // rewriting the tag on a hit stores the same value, so one enable covers both.
    assign line_we = upd_en && upd_taken;

    btp_sat_ctr #(
        .W (CTR_W)
    ) u_sat_ctr (
        .value  (ctr_q[upd_cidx]),
        .inc    (upd_taken),
        .result (ctr_next)
    );

    // Valid bits and counters: reset to empty / weakly not-taken, flush clears valids only.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= WEAK_NT;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_cidx] <= ctr_next;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_cidx]  <= WEAK_T;
            end
        end
    end

    // Tag and target payload, written on taken outcomes.
    always_ff @(posedge CLK) begin
        // NOTE: payload arrays have no reset; valid_q masks their contents until first write.
        if (line_we) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target[31:2];
        end
    end

    assign lint_unused = ^{lk_pc & ~PC_USED, upd_pc & ~PC_USED, upd_target[1:0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (default geometry).
// A behavioural table model follows every edge; a negedge process compares
// all lookup outputs against it each cycle, and directed scenarios pin the
// model with hand-computed literals before a randomized phase.
module tb_branch_target_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int GHR_W   = 6;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int WT      = 1 << (CTR_W - 1);

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] lk_pc = 32'h0;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    logic        flush = 1'b0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    branch_target_predictor #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .CTR_W   (CTR_W),
        .GHR_W   (GHR_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .lk_pc      (lk_pc),
        .lk_hit     (lk_hit),
        .lk_taken   (lk_taken),
        .lk_target  (lk_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .flush      (flush)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_ghr;

    function automatic int unsigned f_idx(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return (p >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return (p >> (2 + IDX_W)) % (1 << TAG_W);
    endfunction

    function automatic int unsigned f_cidx(input logic [31:0] pc);
`ifdef BTP_GSHARE_EN
        return f_idx(pc) ^ m_ghr;
`else
        return f_idx(pc);
`endif
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit h, output bit t,
                                     output logic [31:0] tg);
        int unsigned i;
        i  = f_idx(pc);
        h  = m_valid[i] && (m_tag[i] == f_tag(pc));
        t  = h && (m_ctr[f_cidx(pc)] >= WT);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = WT - 1;
            m_tag[i]   = 0;
            m_tgt[i]   = 32'h0;
        end
        m_ghr = 0;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
        int unsigned i;
        int unsigned ci;
        bit          hit;
        i   = f_idx(pc);
        ci  = f_cidx(pc);
        hit = m_valid[i] && (m_tag[i] == f_tag(pc));
        if (hit) begin
            if (tk) begin
                if (m_ctr[ci] < CMAX) m_ctr[ci] = m_ctr[ci] + 1;
                m_tgt[i] = tg & ~32'h3;
            end else if (m_ctr[ci] > 0) begin
                m_ctr[ci] = m_ctr[ci] - 1;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = f_tag(pc);
            m_tgt[i]   = tg & ~32'h3;
            m_ctr[ci]  = WT;
        end
        m_ghr = ((m_ghr << 1) | (tk ? 1 : 0)) % (1 << GHR_W);
    endfunction

    // Model follows the same edges as the design.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_reset();
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (upd_valid) begin
            m_update(upd_pc, upd_taken, upd_target);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every lookup output against the model.
    always @(negedge CLK) begin
        bit          e_hit;
        bit          e_tk;
        logic [31:0] e_tg;
        if (chk_en) begin
            m_lookup(lk_pc, e_hit, e_tk, e_tg);
            check("cyc_hit", {31'h0, lk_hit}, {31'h0, e_hit});
            check("cyc_taken", {31'h0, lk_taken}, {31'h0, e_tk});
            check("cyc_target", lk_target, e_tg);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input logic [31:0] pc, input bit tk,
                         input logic [31:0] tg, input bit fl);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tg;
        flush      = fl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic expect_lk(input string nm, input logic [31:0] pc, input bit h, input bit t,
                             input logic [31:0] tg);
        lk_pc = pc;
        #1;
        check({nm, "_hit"}, {31'h0, lk_hit}, {31'h0, h});
        check({nm, "_taken"}, {31'h0, lk_taken}, {31'h0, t});
        check({nm, "_target"}, lk_target, tg);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [4];
        tags[0] = 32'h00; tags[1] = 32'h01; tags[2] = 32'h02; tags[3] = 32'hFF;
        return (tags[$urandom_range(0, 3)] << 8) | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios then random ----------------
    initial begin
        int mis;
        lk_pc = 32'h100;
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        chk_en = 1'b1;

        // Reset state.
        expect_lk("reset", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocate on taken miss, then train down.
        drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0); tick();
        expect_lk("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0); tick();
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0); tick();
        expect_lk("two_nt", 32'h100, 1'b1, 1'b0, 32'h104);

        // Same index, different tag: miss, then eviction.
        expect_lk("alias", 32'h200, 1'b0, 1'b0, 32'h204);
        drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b0); tick();
        expect_lk("evict_old", 32'h100, 1'b0, 1'b0, 32'h104);
        expect_lk("evict_new", 32'h200, 1'b1, 1'b1, 32'h300);

        // Same-cycle lookup sees pre-update contents; saturation.
        drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        expect_lk("pre_upd", 32'h40, 1'b0, 1'b0, 32'h44);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0); tick();
        end
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0); tick();
        expect_lk("sat_nt", 32'h40, 1'b1, 1'b1, 32'h80);
        expect_lk("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Flush wins over a simultaneous update.
        drive(1'b1, 32'h300, 1'b1, 32'h500, 1'b1); tick();
        expect_lk("flush_old", 32'h40, 1'b0, 1'b0, 32'h44);
        expect_lk("flush_drop", 32'h300, 1'b0, 1'b0, 32'h304);

        // Reset asserted in the middle of an update cycle.
        drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0); tick();
        expect_lk("realloc", 32'h40, 1'b1, 1'b1, 32'h80);
        drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        #1 RST = 1'b1;
        tick();
        RST = 1'b0;
        expect_lk("rst_mid", 32'h40, 1'b0, 1'b0, 32'h44);

        // Alternating branch at 0x80: predictions taken in the same cycle as training.
        drive(1'b1, 32'h80, 1'b1, 32'h100, 1'b0); tick();
        mis = 0;
        for (int k = 0; k < 40; k++) begin
            lk_pc = 32'h80;
            drive(1'b1, 32'h80, (k % 2) == 1, 32'h100, 1'b0);
            #1;
            if ((k >= 20) && (lk_taken != upd_taken)) mis++;
            tick();
        end
`ifdef BTP_GSHARE_EN
        check("alt_mispredicts", 32'(mis), 32'd0);
`else
        check("alt_mispredicts", 32'(mis), 32'd20);
`endif

        // Randomized traffic over a small aliasing address pool.
        for (int c = 0; c < 3000; c++) begin
            lk_pc = rand_pc();
            drive($urandom_range(0, 2) != 0, rand_pc(), $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 RST = 1'b1;
                tick();
                RST = 1'b0;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
